// File: rtl/procb_thread_out_addr.sv
// Output-side thread addressing for process_bytes: collects per-thread "done" events from the
// SHA512 cores and releases finished threads to the readout logic in strict issue order.
module procb_thread_out_addr #(
  parameter int N_CORES       = 4,
  parameter int N_CORES_MSB   = $clog2(N_CORES) - 1,
  parameter int N_THREADS     = 4 * N_CORES,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     thread_done,
  input  logic [N_THREADS_MSB:0]   thread_done_num,
  output logic                     out_valid,
  output logic [N_THREADS_MSB:0]   out_thread_num,
  input  logic                     out_accept,
  output logic [N_THREADS_MSB+1:0] pending_cnt,
  output logic                     err
);

  localparam int N_CC = 2 * N_CORES;
  localparam int CC_W = N_CORES_MSB + 2;
  localparam int PC_W = N_THREADS_MSB + 2;

  logic [N_THREADS-1:0] r_done_flags;
  logic [N_THREADS-1:0] w_done_flags_nxt;
  logic [CC_W-1:0]      r_core_ctx_ptr;
  logic [N_CC-1:0]      r_seq_exp;
  logic [PC_W-1:0]      r_pending_cnt;
  logic                 r_out_valid;
  logic                 r_err;

  logic [N_THREADS_MSB:0] w_out_num;
  logic                   w_accept;
  logic                   w_bad_accept;
  logic                   w_done_new;
  logic                   w_done_dup;

  // Thread number is {core_ctx, seq}; the expected seq bit of the current core_ctx fills the LSB.
  assign w_out_num    = {r_core_ctx_ptr, r_seq_exp[r_core_ctx_ptr]};
  assign w_accept     = out_accept & r_out_valid;
  assign w_bad_accept = out_accept & ~r_out_valid;
  // A done landing on an accepted thread in the same cycle sees its flag still set -> duplicate.
  assign w_done_dup   = thread_done &  r_done_flags[thread_done_num];
  assign w_done_new   = thread_done & ~r_done_flags[thread_done_num];

  always_comb begin
    // NOTE: assign a default first so every path writes the variable and no latch is inferred.
    w_done_flags_nxt = r_done_flags;
    if (w_accept)
      w_done_flags_nxt[w_out_num] = 1'b0;
    if (w_done_new)
      w_done_flags_nxt[thread_done_num] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: seq_exp is a flop vector rather than RAM precisely so every bit can be reset here.
      r_done_flags   <= '0;
      r_core_ctx_ptr <= '0;
      r_seq_exp      <= '0;
      r_pending_cnt  <= '0;
      r_out_valid    <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every right-hand side sees pre-edge state.
      r_done_flags  <= w_done_flags_nxt;
      r_pending_cnt <= r_pending_cnt + PC_W'(w_done_new) - PC_W'(w_accept);
      r_out_valid   <= w_accept ? 1'b0 : r_done_flags[w_out_num];
      if (w_done_dup || w_bad_accept)
        r_err <= 1'b1;
      if (w_accept) begin
        r_seq_exp[r_core_ctx_ptr] <= ~r_seq_exp[r_core_ctx_ptr];
        r_core_ctx_ptr <= (r_core_ctx_ptr == CC_W'(N_CC - 1)) ? '0
                                                               : r_core_ctx_ptr + CC_W'(1);
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_thread_num = w_out_num;
  assign pending_cnt    = r_pending_cnt;
  assign err            = r_err;

endmodule

// File: doc/procb_thread_out_addr.md
Name: procb_thread_out_addr

Overview:
- Output-side counterpart of the process_bytes input thread addressing.
- Collects "computation finished" events from the SHA512 cores, each tagged with a thread number {core,ctx,seq}.
- Presents finished threads to the output consumer strictly in the order the input side issues them: core_ctx 0..2*N_CORES-1 with wrap, and a per-core_ctx seq bit that toggles after each computation.
- Sits between the cores' done signals and the result-readout logic. Provides the read address (thread number) for the core output buffers.

Parameters:
N_CORES, 4, number of SHA512 cores
N_CORES_MSB, `MSB(N_CORES-1), core index MSB
N_THREADS, 4*N_CORES, threads in total (core x 2 ctx x 2 seq)
N_THREADS_MSB, `MSB(N_THREADS-1), thread number MSB

Ports:
CLK  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
thread_done  in  1  1-cycle pulse: a thread finished computation
thread_done_num  in  N_THREADS_MSB+1  {core_ctx, seq} of the finished thread
out_valid  out  1  out_thread_num is finished and ready for readout
out_thread_num  out  N_THREADS_MSB+1  {core_ctx_ptr, seq_exp[core_ctx_ptr]}
out_accept  in  1  1-cycle pulse: consumer has taken the thread at out_thread_num
pending_cnt  out  N_THREADS_MSB+2  finished-but-not-accepted threads, 0..N_THREADS
err  out  1  sticky protocol error flag

Behaviour:
- State:
  - done_flags[N_THREADS-1:0]
  - core_ctx_ptr, width N_CORES_MSB+2
  - seq_exp[2*N_CORES-1:0]: a register vector, not RAM, because every bit must reset
  - pending_cnt
  - out_valid register
  - err
- Reset (sync, active-high; overrides all other inputs in that cycle):
  - done_flags=0, core_ctx_ptr=0, seq_exp=0, out_valid=0, pending_cnt=0, err=0.
  - out_thread_num therefore reads 0.
- Done capture: a thread_done pulse sampled at edge E sets done_flags[thread_done_num] after E.
  - If that flag was already set, the flag stays set, pending_cnt is not incremented, and err is set.
- Valid generation:
  - out_valid is registered. out_valid <= done_flags[out_thread_num] (current-state value).
  - Latency: thread_done at edge E on the expected thread gives out_valid=1 after edge E+1 (2 cycles).
- Accept (out_accept=1 while out_valid=1, sampled at edge A):
  - Clear done_flags[out_thread_num].
  - seq_exp[core_ctx_ptr] <= ~seq_exp[core_ctx_ptr].
  - core_ctx_ptr <= (core_ctx_ptr == 2*N_CORES-1) ? 0 : core_ctx_ptr+1.
  - out_valid forced to 0 after A. Re-evaluated at A+1, so the earliest next out_valid is after A+1.
- out_accept while out_valid=0: ignored (no state change except err=1).
- out_thread_num is combinational from core_ctx_ptr and seq_exp. It is stable while out_valid=1.
- Strict ordering:
  - A finished thread other than the expected one is held in done_flags.
  - out_valid stays 0 until the expected thread finishes.
  - No skipping, no timeout.
- pending_cnt, net per cycle:
  - +1 on a valid (non-duplicate) done.
  - -1 on a valid accept.
  - Unchanged when both occur in the same cycle on different threads.
- Simultaneous done and accept on the same thread number:
  - The accept is processed: flag cleared, pointer advanced.
  - The done is treated as a duplicate: err=1, flag not re-set.
- Wrap-around:
  - After 2*N_CORES accepts, core_ctx_ptr returns to 0 with every seq_exp bit toggled.
  - After 4*N_CORES accepts, all state returns to its initial values.
- Full: pending_cnt=N_THREADS is legal and cannot overflow, because a new done must be a duplicate and sets err.
- err clears only on reset.
- Reset mid-operation: all pending flags are discarded, and readout restarts at thread 0 on the next cycle.

Test Plan:
- Reset, then done on thread 0 at cycle 1 -> out_valid=1 from cycle 3 with out_thread_num=0 and pending_cnt=1; accept at cycle 4 -> out_valid=0 at cycle 5, pending_cnt=0, out_thread_num=2.
- N_CORES=4, dones in reverse order on threads 14,12,..,0 (seq 0), no accepts -> out_valid stays 0 until thread 0 is done, pending_cnt=8; then accepting every cycle out_valid is high yields out_thread_num sequence 0,2,4,..,14 then 1 (seq_exp[0]=1).
- Run 16 dones and 16 in-order accepts -> all seq_exp return to 0, core_ctx_ptr=0, pending_cnt=0, err=0.
- done on thread 4 twice -> err=1, pending_cnt=1; the err flag persists until reset.
- done on thread 2 in the same cycle as accept of thread 0 -> pending_cnt unchanged (1), out_valid=1 for thread 2 two cycles later.
- Reset asserted with pending_cnt=5 and out_valid=1 -> next cycle out_valid=0, pending_cnt=0, out_thread_num=0, err=0.
